mem_bus_arb: RTL and testbench
==============================

Name: mem_bus_arb

Overview:
- Two-port arbiter and access sequencer for the single asynchronous external memory (ROM/RAM emulation) on the 6809 system bus.
- Shares the memory between the CPU bus interface and the debug/loader port using round-robin grant.
- Drives the memory select, write strobe, address and write data, and inserts a programmable number of wait states.
- Returns read data and a one-cycle acknowledge to the granted requester.

Parameters:
- AW, 8, memory address width in bits.
- WAIT, 2, extra wait cycles per access; legal range 0..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request, level; held until cpu_ack.
- cpu_we  in  1  CPU write (1) / read (0); valid while cpu_req.
- cpu_a  in  AW  CPU address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data, registered.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- dbg_req  in  1  debug/loader request, level; held until dbg_ack.
- dbg_we  in  1  debug write/read.
- dbg_a  in  AW  debug address.
- dbg_din  in  8  debug write data.
- dbg_dout  out  8  debug read data, registered.
- dbg_ack  out  1  one-cycle completion pulse to debug port.
- mem_sel  out  1  memory select.
- mem_we  out  1  memory write strobe; only ever high when mem_sel is high.
- mem_a  out  AW  memory address, registered.
- mem_din  out  8  memory write data, registered.
- mem_dout  in  8  memory read data; combinational from mem_a.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values (all outputs):
  - mem_sel = mem_we = busy = 0.
  - cpu_ack = dbg_ack = 0.
  - mem_a = 0, mem_din = 0.
  - cpu_dout = dbg_dout = 0.
  - Internal: state = IDLE, wait counter = 0, last_grant = DBG, so the CPU wins the first tie.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If no request is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not last_grant.
  - On a grant, at the edge: latch the granted port's a/we/din into mem_a/mem_we/mem_din, set mem_sel = 1, load counter = WAIT, update last_grant, go to ACCESS.
- ACCESS:
  - mem_sel is held at 1; mem_a, mem_we and mem_din are stable.
  - While counter != 0: decrement the counter, stay in ACCESS.
  - When counter == 0:
    - For a read, capture mem_dout into the granted port's dout register.
    - Clear mem_sel and mem_we.
    - Assert the granted port's ack.
    - Go to DONE.
  - ACCESS lasts exactly WAIT+1 cycles.
- DONE:
  - The granted port's ack is high for exactly this one cycle; the other port's ack stays 0.
  - Return to IDLE. Requests are not sampled in DONE.
- Latency: req sampled high in IDLE at edge N:
  - mem_sel is high in cycles N+1 .. N+1+WAIT.
  - ack is high in cycle N+2+WAIT.
  - Read data is valid in dout from that cycle onward.
- Port data registers:
  - A write access leaves that port's dout unchanged.
  - Each port's dout holds its value until that port's next read completes.
  - The non-granted port's dout never changes.
- Requester protocol:
  - The requester deasserts req at the edge ending its ack cycle.
  - If req is still high in the following IDLE cycle, that counts as a new request.
- Minimum spacing: back-to-back accesses from alternating ports are spaced WAIT+3 cycles apart, ack to ack.
- req dropped during ACCESS: the access completes and ack still pulses; aborts are not supported.
- Requester inputs (a/we/din) changing during ACCESS have no effect; they are latched at grant.
- Writes to ROM-backed addresses are sequenced normally and acked; the arbiter does not decode memory type.
- Reset asserted in any state: returns to IDLE with reset values at the next edge, with no ack generated. The in-flight access is discarded, and a write may be partially applied to memory.
- Starvation: with both ports requesting continuously, grants strictly alternate CPU, DBG, CPU, ...

Test Plan:
- Bench memory model: mem_dout = mem_a XOR 8'hA5, combinational.
- WAIT=2, CPU read a=0x10 asserted alone at edge 0 -> mem_sel high in cycles 1-3, cpu_ack high only in cycle 4, cpu_dout=0xB5, dbg_ack stays 0.
- Both req high from reset, both reads (cpu_a=0x00, dbg_a=0xFE) -> CPU granted first, cpu_dout=0xA5; then DBG granted, dbg_dout=0x5B; acks exactly WAIT+3 cycles apart.
- WAIT=0, DBG write a=0x20 din=0x3C -> mem_sel=mem_we=1 for exactly one cycle with mem_a=0x20, mem_din=0x3C; dbg_ack on the next cycle; dbg_dout unchanged.
- CPU read in progress with rst pulsed in the second ACCESS cycle -> next cycle mem_sel=0, busy=0, no cpu_ack, cpu_dout=0x00; a subsequent CPU request is granted first.
- Both ports holding req high for 6 accesses -> grant order CPU, DBG, CPU, DBG, CPU, DBG; mem_we is never high while mem_sel is low.

Source files
------------

// File: rtl/mem_bus_arb.sv
// Round-robin arbiter and access sequencer for the shared asynchronous memory.
// A CPU port and a debug/loader port share the memory; each access has a programmable number of wait states.
module mem_bus_arb #(
    parameter int unsigned AW   = 8,
    parameter int unsigned WAIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_a,
    input  logic [7:0]    dbg_din,
    output logic [7:0]    dbg_dout,
    output logic          dbg_ack,
    output logic          mem_sel,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    output logic          busy
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          last_dbg_q;
    logic          owner_dbg_q;
    logic          mem_sel_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_a_q;
    logic [7:0]    mem_din_q;
    logic [7:0]    cpu_dout_q;
    logic [7:0]    dbg_dout_q;
    logic          cpu_ack_q;
    logic          dbg_ack_q;
    logic          busy_q;

    logic          gnt_vld_d;
    logic          gnt_dbg_d;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        gnt_vld_d = cpu_req | dbg_req;
        gnt_dbg_d = dbg_req & (~cpu_req | ~last_dbg_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_dbg_q  <= 1'b1;
            owner_dbg_q <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_din_q   <= '0;
            cpu_dout_q  <= '0;
            dbg_dout_q  <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld_d) begin
                        state_q     <= S_ACCESS;
                        busy_q      <= 1'b1;
                        mem_sel_q   <= 1'b1;
                        mem_we_q    <= gnt_dbg_d ? dbg_we  : cpu_we;
                        mem_a_q     <= gnt_dbg_d ? dbg_a   : cpu_a;
                        mem_din_q   <= gnt_dbg_d ? dbg_din : cpu_din;
                        cnt_q       <= CW'(WAIT);
                        last_dbg_q  <= gnt_dbg_d;
                        owner_dbg_q <= gnt_dbg_d;
                    end
                end
                S_ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        if (!mem_we_q) begin
                            if (owner_dbg_q) dbg_dout_q <= mem_dout;
                            else             cpu_dout_q <= mem_dout;
                        end
                        mem_sel_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        cpu_ack_q <= ~owner_dbg_q;
                        dbg_ack_q <= owner_dbg_q;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    cpu_ack_q <= 1'b0;
                    dbg_ack_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_sel  = mem_sel_q;
    assign mem_we   = mem_we_q;
    assign mem_a    = mem_a_q;
    assign mem_din  = mem_din_q;
    assign cpu_dout = cpu_dout_q;
    assign dbg_dout = dbg_dout_q;
    assign cpu_ack  = cpu_ack_q;
    assign dbg_ack  = dbg_ack_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb: one instance with WAIT=2, one with WAIT=0.
// Memory model returns address XOR 0xA5.
module tb_mem_bus_arb;

    logic       clk;
    logic       rst;

    logic       cpu_req, cpu_we, cpu_ack, dbg_req, dbg_we, dbg_ack;
    logic [7:0] cpu_a, cpu_din, cpu_dout, dbg_a, dbg_din, dbg_dout;
    logic       mem_sel, mem_we, busy;
    logic [7:0] mem_a, mem_din, mem_dout;

    logic       z_cpu_req, z_cpu_we, z_cpu_ack, z_dbg_req, z_dbg_we, z_dbg_ack;
    logic [7:0] z_cpu_a, z_cpu_din, z_cpu_dout, z_dbg_a, z_dbg_din, z_dbg_dout;
    logic       z_mem_sel, z_mem_we, z_busy;
    logic [7:0] z_mem_a, z_mem_din, z_mem_dout;

    int checks = 0;
    int fails  = 0;

    assign mem_dout   = mem_a ^ 8'hA5;
    assign z_mem_dout = z_mem_a ^ 8'hA5;

    mem_bus_arb #(.AW(8), .WAIT(2)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_a(dbg_a), .dbg_din(dbg_din),
        .dbg_dout(dbg_dout), .dbg_ack(dbg_ack),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_a(mem_a), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    mem_bus_arb #(.AW(8), .WAIT(0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_a(z_cpu_a), .cpu_din(z_cpu_din),
        .cpu_dout(z_cpu_dout), .cpu_ack(z_cpu_ack),
        .dbg_req(z_dbg_req), .dbg_we(z_dbg_we), .dbg_a(z_dbg_a), .dbg_din(z_dbg_din),
        .dbg_dout(z_dbg_dout), .dbg_ack(z_dbg_ack),
        .mem_sel(z_mem_sel), .mem_we(z_mem_we), .mem_a(z_mem_a), .mem_din(z_mem_din),
        .mem_dout(z_mem_dout), .busy(z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int         nack;
        logic [5:0] order;

        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = 8'h00; cpu_din = 8'h00;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_a = 8'h00; dbg_din = 8'h00;
        z_cpu_req = 1'b0; z_cpu_we = 1'b0; z_cpu_a = 8'h00; z_cpu_din = 8'h00;
        z_dbg_req = 1'b0; z_dbg_we = 1'b0; z_dbg_a = 8'h00; z_dbg_din = 8'h00;
        cyc(); cyc();

        chk("rst_mem_sel",  32'(mem_sel),  32'(0));
        chk("rst_mem_we",   32'(mem_we),   32'(0));
        chk("rst_busy",     32'(busy),     32'(0));
        chk("rst_cpu_ack",  32'(cpu_ack),  32'(0));
        chk("rst_dbg_ack",  32'(dbg_ack),  32'(0));
        chk("rst_mem_a",    32'(mem_a),    32'(0));
        chk("rst_mem_din",  32'(mem_din),  32'(0));
        chk("rst_cpu_dout", 32'(cpu_dout), 32'(0));
        chk("rst_dbg_dout", 32'(dbg_dout), 32'(0));

        // CPU read of 0x10 alone; address change mid-access must be ignored.
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 8'h10;
        cyc();
        chk("t1_c1_sel",  32'(mem_sel), 32'(1));
        chk("t1_c1_a",    32'(mem_a),   32'(8'h10));
        chk("t1_c1_busy", 32'(busy),    32'(1));
        chk("t1_c1_ack",  32'(cpu_ack), 32'(0));
        cpu_a = 8'h77;
        cyc();
        chk("t1_c2_sel", 32'(mem_sel), 32'(1));
        chk("t1_c2_a",   32'(mem_a),   32'(8'h10));
        cyc();
        chk("t1_c3_sel", 32'(mem_sel), 32'(1));
        chk("t1_c3_ack", 32'(cpu_ack), 32'(0));
        cyc();
        chk("t1_c4_sel",  32'(mem_sel),  32'(0));
        chk("t1_c4_ack",  32'(cpu_ack),  32'(1));
        chk("t1_c4_dack", 32'(dbg_ack),  32'(0));
        chk("t1_c4_dout", 32'(cpu_dout), 32'(8'hB5));
        chk("t1_c4_ddo",  32'(dbg_dout), 32'(0));
        cpu_req = 1'b0;
        cyc();
        chk("t1_c5_ack",  32'(cpu_ack), 32'(0));
        chk("t1_c5_busy", 32'(busy),    32'(0));

        // Both ports request from reset: CPU first, DBG WAIT+3 cycles later.
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 8'h00;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_a = 8'hFE;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("t2_cpu_a",   32'(mem_a),   32'(8'h00));
        chk("t2_cpu_sel", 32'(mem_sel), 32'(1));
        cyc(); cyc(); cyc();
        chk("t2_cpu_ack",  32'(cpu_ack),  32'(1));
        chk("t2_cpu_dack", 32'(dbg_ack),  32'(0));
        chk("t2_cpu_dout", 32'(cpu_dout), 32'(8'hA5));
        cpu_req = 1'b0;
        cyc();
        chk("t2_idle_busy", 32'(busy), 32'(0));
        cyc();
        chk("t2_dbg_a", 32'(mem_a), 32'(8'hFE));
        cyc(); cyc();
        chk("t2_dbg_early", 32'(dbg_ack), 32'(0));
        cyc();
        chk("t2_dbg_ack",  32'(dbg_ack),  32'(1));
        chk("t2_dbg_cack", 32'(cpu_ack),  32'(0));
        chk("t2_dbg_dout", 32'(dbg_dout), 32'(8'h5B));
        chk("t2_cpu_keep", 32'(cpu_dout), 32'(8'hA5));
        dbg_req = 1'b0;
        cyc();
        chk("t2_dbg_ackoff", 32'(dbg_ack), 32'(0));

        // WAIT=0 instance: debug read to preload dout, then a debug write.
        z_dbg_req = 1'b1; z_dbg_we = 1'b0; z_dbg_a = 8'h33;
        cyc();
        chk("t3_rd_sel", 32'(z_mem_sel), 32'(1));
        cyc();
        chk("t3_rd_ack",  32'(z_dbg_ack),  32'(1));
        chk("t3_rd_dout", 32'(z_dbg_dout), 32'(8'h96));
        z_dbg_req = 1'b0;
        cyc();
        z_dbg_req = 1'b1; z_dbg_we = 1'b1; z_dbg_a = 8'h20; z_dbg_din = 8'h3C;
        cyc();
        chk("t3_wr_sel", 32'(z_mem_sel), 32'(1));
        chk("t3_wr_we",  32'(z_mem_we),  32'(1));
        chk("t3_wr_a",   32'(z_mem_a),   32'(8'h20));
        chk("t3_wr_din", 32'(z_mem_din), 32'(8'h3C));
        chk("t3_wr_ack0", 32'(z_dbg_ack), 32'(0));
        cyc();
        chk("t3_wr_sel0", 32'(z_mem_sel),  32'(0));
        chk("t3_wr_we0",  32'(z_mem_we),   32'(0));
        chk("t3_wr_ack",  32'(z_dbg_ack),  32'(1));
        chk("t3_wr_dout", 32'(z_dbg_dout), 32'(8'h96));
        chk("t3_wr_cack", 32'(z_cpu_ack),  32'(0));
        z_dbg_req = 1'b0;
        cyc();
        chk("t3_ackoff", 32'(z_dbg_ack), 32'(0));

        // Reset during the second ACCESS cycle of a CPU read.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 8'h44;
        cyc();
        chk("t4_sel", 32'(mem_sel), 32'(1));
        cyc();
        rst = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_a = 8'h55; dbg_din = 8'h99;
        cyc();
        chk("t4_rst_sel",  32'(mem_sel),  32'(0));
        chk("t4_rst_busy", 32'(busy),     32'(0));
        chk("t4_rst_ack",  32'(cpu_ack),  32'(0));
        chk("t4_rst_dout", 32'(cpu_dout), 32'(0));
        rst = 1'b0;
        cyc();
        chk("t4_regrant_a",  32'(mem_a),  32'(8'h44));
        chk("t4_regrant_we", 32'(mem_we), 32'(0));

        // Both ports keep requesting: grants must alternate starting with CPU.
        nack  = 0;
        order = '0;
        for (int i = 0; i < 60 && nack < 6; i++) begin
            if (i > 0) cyc();
            chk("t5_we_wo_sel", 32'(mem_we & ~mem_sel), 32'(0));
            chk("t5_both_ack",  32'(cpu_ack & dbg_ack), 32'(0));
            if (cpu_ack) begin
                order = {order[4:0], 1'b0};
                nack++;
            end else if (dbg_ack) begin
                order = {order[4:0], 1'b1};
                nack++;
            end
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        chk("t5_nack",  32'(nack),  32'(6));
        chk("t5_order", 32'(order), 32'(6'b010101));
        cyc(); cyc();
        chk("t5_busy",     32'(busy),     32'(0));
        chk("t5_cpu_dout", 32'(cpu_dout), 32'(8'hE1));
        chk("t5_dbg_dout", 32'(dbg_dout), 32'(0));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
